// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
//   arb_state_t : FSM encodings ARB_IDLE / ARB_BUSY
//   arb_own_t   : transaction owner codes ARB_OWN_I / ARB_OWN_D
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_own_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch (I) and load/store (D) requests.
// Configuration macro: MEM_ARB_RR_EN
//   undefined : fixed priority, D beats I on a tie
//   defined   : round-robin, the side not granted last wins a tie
// Ports:
//   i_req, d_req : pending requests
//   last         : owner of the most recent grant (round-robin build only)
//   sel_i, sel_d : one-hot winner, both 0 when nobody requests
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  arb_own_t last,
`endif
  input  logic     i_req,
  input  logic     d_req,
  output logic     sel_i,
  output logic     sel_d
);

  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      sel_i = (last == ARB_OWN_D);
      sel_d = (last == ARB_OWN_I);
`else
      sel_d = 1'b1;
`endif
    end else begin
      sel_i = i_req;
      sel_d = d_req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (I)
// and load/store (D). One transaction in flight; read data returns MEM_LAT
// cycles after issue and is passed straight through to the owner.
// Configuration macro: MEM_ARB_RR_EN (round-robin tie-break, see mem_arb_pick).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt          : fetch request and accept pulse
//   i_rvalid/i_rdata               : fetch response
//   d_req/d_we/d_addr/d_wdata      : load/store request, d_gnt accept pulse
//   d_rvalid/d_rdata               : load data / store completion
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory side
//   busy                           : transaction in flight
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  arb_state_t    state, state_nxt;
  arb_own_t      owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sel_i, sel_d;
  logic          resp, can_grant;

  // Winner select; the current owner doubles as the last-grant record.
  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .last  (owner),
`endif
    .i_req (i_req),
    .d_req (d_req),
    .sel_i (sel_i),
    .sel_d (sel_d)
  );

  // State, owner and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= ARB_OWN_D;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The response cycle (cnt==1) is also a grant slot, giving back-to-back issue.
  assign resp      = (state == ARB_BUSY) && (cnt == CW'(1));
  assign can_grant = (state == ARB_IDLE) || resp;
  assign busy      = (state == ARB_BUSY);
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  // Next state, grants, response pulses and memory drive.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (resp) begin
      i_rvalid = (owner == ARB_OWN_I);
      d_rvalid = (owner == ARB_OWN_D);
    end

    if (state == ARB_BUSY) begin
      cnt_nxt = cnt - CW'(1);
      if (resp) state_nxt = ARB_IDLE;
    end

    if (can_grant && sel_d) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      owner_nxt = ARB_OWN_D;
      cnt_nxt   = CW'(MEM_LAT);
      state_nxt = ARB_BUSY;
    end else if (can_grant && sel_i) begin
      i_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = i_addr;
      owner_nxt = ARB_OWN_I;
      cnt_nxt   = CW'(MEM_LAT);
      state_nxt = ARB_BUSY;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A (MEM_LAT=2) with a writable
// memory model, B (MEM_LAT=3) and C (MEM_LAT=1) with read-only pattern memories.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- instance A, MEM_LAT=2 ----------------
  logic        a_i_req, a_d_req, a_d_we;
  logic [31:0] a_i_addr, a_d_addr, a_d_wdata;
  logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid;
  logic [31:0] a_i_rdata, a_d_rdata;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt),
    .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  logic [31:0] mem_a [4096];
  logic [31:0] pa0, pa1;
  initial for (int i = 0; i < 4096; i++) mem_a[i] = pat(32'(i) << 2);
  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) mem_a[a_mem_addr[13:2]] <= a_mem_wdata;
      pa0 <= mem_a[a_mem_addr[13:2]];
    end else begin
      pa0 <= 32'h0;
    end
    pa1 <= pa0;
  end
  assign a_mem_rdata = pa1;

  wire [6:0]  a_flags = {a_i_gnt, a_d_gnt, a_i_rvalid, a_d_rvalid, a_mem_en, a_mem_we, a_busy};
  wire [31:0] a_rsel  = a_i_rvalid ? a_i_rdata : a_d_rdata;

  // ---------------- instance B, MEM_LAT=3 ----------------
  logic        b_i_req;
  logic [31:0] b_i_addr;
  logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid;
  logic [31:0] b_i_rdata, b_d_rdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [31:0] pb0, pb1, pb2;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt),
    .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  always @(posedge clk) begin
    pb0 <= b_mem_en ? pat(b_mem_addr) : 32'h0;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign b_mem_rdata = pb2;

  wire [6:0]  b_flags = {b_i_gnt, b_d_gnt, b_i_rvalid, b_d_rvalid, b_mem_en, b_mem_we, b_busy};

  // ---------------- instance C, MEM_LAT=1 ----------------
  logic        c_d_req;
  logic [31:0] c_d_addr;
  logic        c_i_gnt, c_i_rvalid, c_d_gnt, c_d_rvalid;
  logic [31:0] c_i_rdata, c_d_rdata;
  logic        c_mem_en, c_mem_we, c_busy;
  logic [31:0] c_mem_addr, c_mem_wdata, c_mem_rdata;
  logic [31:0] pc0;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_c (
    .clk(clk), .rst(rst),
    .i_req(1'b0), .i_addr(32'h0), .i_gnt(c_i_gnt),
    .i_rvalid(c_i_rvalid), .i_rdata(c_i_rdata),
    .d_req(c_d_req), .d_we(1'b0), .d_addr(c_d_addr), .d_wdata(32'h0),
    .d_gnt(c_d_gnt), .d_rvalid(c_d_rvalid), .d_rdata(c_d_rdata),
    .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
    .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata), .busy(c_busy)
  );

  always @(posedge clk) pc0 <= c_mem_en ? pat(c_mem_addr) : 32'h0;
  assign c_mem_rdata = pc0;

  wire [6:0]  c_flags = {c_i_gnt, c_d_gnt, c_i_rvalid, c_d_rvalid, c_mem_en, c_mem_we, c_busy};

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  // flags = {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy}
  task automatic cmp(input string nm,
                     input logic [6:0] af, input logic [31:0] aa, input logic [31:0] aw,
                     input logic [31:0] ar,
                     input logic [6:0] ef, input logic [31:0] ea, input logic [31:0] ew,
                     input logic chk, input logic [31:0] er);
    n_vec++;
    if (af !== ef || aa !== ea || aw !== ew || (chk && ar !== er)) begin
      n_bad++;
      $display("FAIL %s: got flags=%b addr=%h wdata=%h rdata=%h, want flags=%b addr=%h wdata=%h rdata=%h%s",
               nm, af, aa, aw, ar, ef, ea, ew, er, chk ? "" : "(rdata not checked)");
    end
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [6:0]  ef;
    logic [31:0] ea;
    logic [31:0] ew;
    logic        chk;
    logic [31:0] er;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                              input logic [6:0] ef, input logic [31:0] ea, input logic [31:0] ew,
                              input logic chk, input logic [31:0] er);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.ef = ef; v.ea = ea; v.ew = ew; v.chk = chk; v.er = er;
    return v;
  endfunction

  task automatic drive_a(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    a_i_req = ir; a_i_addr = ia; a_d_req = dr; a_d_we = dwe; a_d_addr = da; a_d_wdata = dwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table for instance A, one entry per clock, starting from idle after reset.
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0000000, 32'h0,    32'h0, 0, 32'h0));
`ifdef MEM_ARB_RR_EN
    vq.push_back(mk(1, 32'h100, 1, 0, 32'h2000, 32'h0, 7'b1000100, 32'h100,  32'h0, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   1, 0, 32'h2000, 32'h0, 7'b0000001, 32'h0,    32'h0, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   1, 0, 32'h2000, 32'h0, 7'b0110101, 32'h2000, 32'h0, 1, 32'h5A5A0100));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0000001, 32'h0,    32'h0, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0001001, 32'h0,    32'h0, 1, 32'h5A5A2000));
`else
    vq.push_back(mk(1, 32'h100, 1, 0, 32'h2000, 32'h0, 7'b0100100, 32'h2000, 32'h0, 0, 32'h0));
    vq.push_back(mk(1, 32'h100, 0, 0, 32'h0,    32'h0, 7'b0000001, 32'h0,    32'h0, 0, 32'h0));
    vq.push_back(mk(1, 32'h100, 0, 0, 32'h0,    32'h0, 7'b1001101, 32'h100,  32'h0, 1, 32'h5A5A2000));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0000001, 32'h0,    32'h0, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0010001, 32'h0,    32'h0, 1, 32'h5A5A0100));
`endif
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0000000, 32'h0,    32'h0, 0, 32'h0));
    // store 0x40 then load it back
    vq.push_back(mk(0, 32'h0,   1, 1, 32'h40, 32'hDEADBEEF, 7'b0100110, 32'h40, 32'hDEADBEEF, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0000001, 32'h0,    32'h0, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0001001, 32'h0,    32'h0, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   1, 0, 32'h40,   32'h0, 7'b0100100, 32'h40,   32'h0, 0, 32'h0));
    // fetch request raised mid-transaction and dropped before a grant slot
    vq.push_back(mk(1, 32'h300, 0, 0, 32'h0,    32'h0, 7'b0000001, 32'h0,    32'h0, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0001001, 32'h0,    32'h0, 1, 32'hDEADBEEF));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0000000, 32'h0,    32'h0, 0, 32'h0));
    // D payload changes while waiting; the current payload is used
    vq.push_back(mk(1, 32'h100, 0, 0, 32'h0,    32'h0, 7'b1000100, 32'h100,  32'h0, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   1, 0, 32'h3000, 32'h0, 7'b0000001, 32'h0,    32'h0, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   1, 0, 32'h44,   32'h0, 7'b0110101, 32'h44,   32'h0, 1, 32'h5A5A0100));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0000001, 32'h0,    32'h0, 0, 32'h0));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0001001, 32'h0,    32'h0, 1, 32'h5A5A0044));
    vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0, 7'b0000000, 32'h0,    32'h0, 0, 32'h0));

    rst = 1'b1;
    drive_a(0, 32'h0, 0, 0, 32'h0, 32'h0);
    b_i_req = 1'b0; b_i_addr = 32'h0;
    c_d_req = 1'b0; c_d_addr = 32'h0;
    repeat (2) next_cycle();

    // reset values
    @(negedge clk);
    cmp("reset_a", a_flags, a_mem_addr, a_mem_wdata, a_rsel, 7'b0, 32'h0, 32'h0, 0, 32'h0);
    cmp("reset_b", b_flags, b_mem_addr, b_mem_wdata, b_i_rdata, 7'b0, 32'h0, 32'h0, 0, 32'h0);
    cmp("reset_c", c_flags, c_mem_addr, c_mem_wdata, c_d_rdata, 7'b0, 32'h0, 32'h0, 0, 32'h0);
    next_cycle();
    rst = 1'b0;

    // table-driven vectors on A
    foreach (vq[k]) begin
      drive_a(vq[k].ir, vq[k].ia, vq[k].dr, vq[k].dwe, vq[k].da, vq[k].dwd);
      @(negedge clk);
      cmp($sformatf("vec%0d", k), a_flags, a_mem_addr, a_mem_wdata, a_rsel,
          vq[k].ef, vq[k].ea, vq[k].ew, vq[k].chk, vq[k].er);
      next_cycle();
    end

    // reset one cycle after a grant drops the access
    drive_a(1, 32'h100, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    cmp("rst_mid_gnt", a_flags, a_mem_addr, a_mem_wdata, a_rsel, 7'b1000100, 32'h100, 32'h0, 0, 32'h0);
    next_cycle();
    drive_a(0, 32'h0, 0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    cmp("rst_mid_norv", a_flags, a_mem_addr, a_mem_wdata, a_rsel, 7'b0, 32'h0, 32'h0, 0, 32'h0);
    next_cycle();
    drive_a(1, 32'h104, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    cmp("rst_mid_regnt", a_flags, a_mem_addr, a_mem_wdata, a_rsel, 7'b1000100, 32'h104, 32'h0, 0, 32'h0);
    next_cycle();
    drive_a(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    cmp("rst_mid_wait", a_flags, a_mem_addr, a_mem_wdata, a_rsel, 7'b0000001, 32'h0, 32'h0, 0, 32'h0);
    next_cycle();
    @(negedge clk);
    cmp("rst_mid_rv", a_flags, a_mem_addr, a_mem_wdata, a_rsel, 7'b0010001, 32'h0, 32'h0, 1, 32'h5A5A0104);
    next_cycle();

    // B: continuous fetch with MEM_LAT=3
    b_i_req = 1'b1; b_i_addr = 32'h100;
    for (int k = 0; k < 10; k++) begin
      logic g, rv;
      g  = (k % 3 == 0);
      rv = g && (k > 0);
      @(negedge clk);
      cmp($sformatf("lat3_cyc%0d", k), b_flags, b_mem_addr, b_mem_wdata, b_i_rdata,
          {g, 1'b0, rv, 1'b0, g, 1'b0, k > 0}, g ? 32'h100 : 32'h0, 32'h0, rv, 32'h5A5A0100);
      next_cycle();
    end
    b_i_req = 1'b0;

    // C: back-to-back loads with MEM_LAT=1
    for (int k = 0; k < 5; k++) begin
      logic g, rv;
      g  = (k < 4);
      rv = (k > 0);
      c_d_req  = g;
      c_d_addr = g ? 32'h10 + 32'(4 * k) : 32'h0;
      @(negedge clk);
      cmp($sformatf("lat1_cyc%0d", k), c_flags, c_mem_addr, c_mem_wdata, c_d_rdata,
          {1'b0, g, 1'b0, rv, g, 1'b0, rv}, g ? 32'h10 + 32'(4 * k) : 32'h0, 32'h0,
          rv, pat(32'h10 + 32'(4 * (k - 1))));
      next_cycle();
    end
    c_d_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
